// File: rtl/calc_inverter.sv
`timescale 1ns / 1ps
// calc_inverter: iterative inverse of the square/cube/factorial calculator.
// Define CALC_INV_EARLY_EXIT_EN to end square/cube misses once f(k) exceeds value.
module calc_inverter (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] opcode,
    input  logic [8:0] value,
    output logic       busy,
    output logic       done,
    output logic [2:0] x,
    output logic       match
);

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [2:0] x_q, x_d;
    logic       match_q, match_d;
    logic [8:0] val_q, val_d;
    logic [1:0] op_q, op_d;

    logic [8:0] kk;
    logic [8:0] fk;
    logic       hit;
    logic       over;

    assign kk = {6'd0, k_q};

    // Forward map for the current candidate; 9 bits never overflow (7^3 = 343).
    always_comb begin
        fk = '0;
        case (op_q)
            2'd0: fk = kk * kk;
            2'd1: fk = kk * kk * kk;
            2'd2: begin
                case (k_q)
                    3'd0, 3'd1: fk = 9'd1;
                    3'd2:       fk = 9'd2;
                    3'd3:       fk = 9'd6;
                    3'd4:       fk = 9'd24;
                    3'd5:       fk = 9'd120;
                    default:    fk = 9'd0;
                endcase
            end
            default: fk = '0;
        endcase
    end

    assign hit = (fk == val_q);

`ifdef CALC_INV_EARLY_EXIT_EN
    // Square and cube are monotonic, so overshooting value means no later k can match.
    assign over = ((op_q == 2'd0) || (op_q == 2'd1)) && (fk > val_q);
`else
    assign over = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        match_d = match_q;
        val_d   = val_q;
        op_d    = op_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    val_d   = value;
                    op_d    = opcode;
                    k_d     = 3'd0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (hit) begin
                    x_d     = k_q;
                    match_d = 1'b1;
                    state_d = StDone;
                end else if ((k_q == 3'd7) || over) begin
                    x_d     = 3'd0;
                    match_d = 1'b0;
                    state_d = StDone;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
            x_q     <= 3'd0;
            match_q <= 1'b0;
            val_q   <= 9'd0;
            op_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            match_q <= match_d;
            val_q   <= val_d;
            op_q    <= op_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign x     = x_q;
    assign match = match_q;

endmodule

// File: tb/tb_calc_inverter.sv
`timescale 1ns / 1ps
// Bench for calc_inverter: directed requests, scoreboard of expected x/match/latency.
module tb_calc_inverter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] opcode;
    logic [8:0] value;
    logic       busy;
    logic       done;
    logic [2:0] x;
    logic       match;

    typedef struct {
        logic [2:0]  x;
        logic        match;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    calc_inverter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .match  (match)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    endtask

    // Reference forward calculator.
    function automatic logic [8:0] fwd(input logic [1:0] op, input logic [2:0] k);
        logic [8:0] kv;
        kv = {6'd0, k};
        case (op)
            2'd0: return kv * kv;
            2'd1: return kv * kv * kv;
            2'd2: begin
                case (k)
                    3'd0:    return 9'd1;
                    3'd1:    return 9'd1;
                    3'd2:    return 9'd2;
                    3'd3:    return 9'd6;
                    3'd4:    return 9'd24;
                    3'd5:    return 9'd120;
                    default: return 9'd0;
                endcase
            end
            default: return 9'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [8:0] val);
        exp_t e;
        bit   found;
        e.x     = 3'd0;
        e.match = 1'b0;
        e.lat   = 9;
        found   = 0;
        for (int k = 0; k < 8; k++) begin
            if (!found) begin
                if (fwd(op, k[2:0]) == val) begin
                    found   = 1;
                    e.x     = k[2:0];
                    e.match = 1'b1;
                    e.lat   = k + 2;
                end
`ifdef CALC_INV_EARLY_EXIT_EN
                else if ((op < 2'd2) && (fwd(op, k[2:0]) > val)) begin
                    found = 1;
                    e.lat = k + 2;
                end
`endif
            end
        end
        return e;
    endfunction

    // n = posedges already seen after the start-sampling edge.
    task automatic wait_and_check(input int n_in, input string tag);
        exp_t e;
        int   n;
        n = n_in;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_x"}, x, e.x);
        check({tag, "_match"}, match, e.match);
        check({tag, "_latency"}, n + 1, e.lat);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_x_held"}, x, e.x);
    endtask

    task automatic launch(input logic [1:0] op, input logic [8:0] val);
        sb.push_back(model(op, val));
        @(negedge clk);
        opcode = op;
        value  = val;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        // Changes after acceptance must not disturb the search.
        opcode = ~op;
        value  = ~val;
    endtask

    task automatic run_req(input logic [1:0] op, input logic [8:0] val, input string tag);
        launch(op, val);
        check({tag, "_busy"}, busy, 1'b1);
        wait_and_check(0, tag);
    endtask

    initial begin
        int dcount;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = 2'd0;
        value  = 9'd0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_x", x, 3'd0);
        check("rst_match", match, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_req(2'd0, 9'd25, "sq25");
        run_req(2'd0, 9'd0, "sq0");
        run_req(2'd1, 9'd343, "cu343");
        run_req(2'd1, 9'd8, "cu8");
        run_req(2'd2, 9'd120, "fa120");
        run_req(2'd2, 9'd1, "fa1");
        run_req(2'd2, 9'd0, "fa0");
        run_req(2'd2, 9'd7, "fa7");
        run_req(2'd0, 9'd26, "sq26");
        run_req(2'd3, 9'd0, "nu0");
        run_req(2'd3, 9'd5, "nu5");

        // A start pulse while busy is ignored.
        launch(2'd1, 9'd64);
        @(negedge clk);
        @(negedge clk);
        opcode = 2'd0;
        value  = 9'd9;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", busy, 1'b1);
        check("ign_no_done", done, 1'b0);
        wait_and_check(2, "ign");

        // Asynchronous reset mid-search: outputs clear at once, no done follows.
        @(negedge clk);
        opcode = 2'd0;
        value  = 9'd49;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_x", x, 3'd0);
        check("arst_match", match, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("arst_no_done", dcount, 0);
        run_req(2'd0, 9'd49, "post_rst");

        // Round trip through the forward calculator for every operand and opcode.
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 8; k++) begin
                logic [8:0] v;
                v = fwd(op[1:0], k[2:0]);
                run_req(op[1:0], v, "sweep");
                check("sweep_roundtrip", fwd(op[1:0], x), v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
